apb_slave_asynch: RTL
=====================

// Module: apb_slave_asynch
// PURPOSE
//  Destination-domain end of the APB CDC. Receives the 4-phase req/ack handshake and the
//  quasi-static APB request bundle from the source-domain master end. Replays the request
//  as a standard two-phase APB transfer on its local APB master port. Returns PRDATA and
//  PSLVERR plus ack: req_i^ -> ack_o^ -> req_i_ -> ack_o_.
// PARAMETERS
//  APB_DATA_WIDTH  32  width of PWDATA/PRDATA (both sides)
//  APB_ADDR_WIDTH  32  width of PADDR (both sides)
// PORTS
//  clk              in   1   destination-domain clock
//  rst_n            in   1   asynchronous active-low reset
//  asynch_req_i     in   1   request from source domain (async, synchronised here)
//  asynch_ack_o     out  1   acknowledge to source domain (registered)
//  async_PADDR_i    in   AW  request address, stable while req_i high
//  async_PWDATA_i   in   DW  request write data, stable while req_i high
//  async_PWRITE_i   in   1   request direction, 1=write
//  async_PSEL_i     in   1   request select; 0 = null request
//  async_PRDATA_o   out  DW  captured read data (registered)
//  async_PSLVERR_o  out  1   captured slave error (registered)
//  PADDR_o          out  AW  local APB address
//  PWDATA_o         out  DW  local APB write data
//  PWRITE_o         out  1   local APB direction
//  PSEL_o           out  1   local APB select
//  PENABLE_o        out  1   local APB enable
//  PRDATA_i         in   DW  local APB read data
//  PREADY_i         in   1   local APB ready
//  PSLVERR_i        in   1   local APB error
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; req synchroniser FFs 0.
//  - asynch_req_i passes through 2 FFs -> req_sync. No other async input is synchronised.
//    They are sampled only while req_sync=1, when the master holds them stable.
//  - FSM states, all outputs registered:
//    IDLE:   req_sync=1 and async_PSEL_i=1 -> capture PADDR/PWDATA/PWRITE into output regs;
//            PSEL_o<=1 -> SETUP.
//            req_sync=1 and async_PSEL_i=0 -> async_PSLVERR_o<=0; ack_o<=1 -> WAIT_REQ_LOW.
//            async_PRDATA_o is left unchanged.
//    SETUP:  PSEL_o=1, PENABLE_o=0, one cycle; PENABLE_o<=1 -> ACCESS.
//    ACCESS: PSEL_o=1, PENABLE_o=1 until PREADY_i=1.
//            On PREADY_i: async_PRDATA_o<=PRDATA_i (reads and writes alike) and
//            async_PSLVERR_o<=PSLVERR_i; PSEL_o<=0; PENABLE_o<=0; ack_o<=1 -> WAIT_REQ_LOW.
//    WAIT_REQ_LOW: ack_o=1; req_sync=0 -> ack_o<=0 -> IDLE.
//  - Latency: T0 = first cycle req_sync=1 in IDLE. PSEL_o rises T0+1, PENABLE_o rises T0+2.
//    With PREADY_i=1 at T0+2, ack_o rises T0+3. Each PREADY_i=0 cycle adds 1.
//  - async_PRDATA_o/async_PSLVERR_o change only on a capture. They stay stable while ack_o=1
//    and until the next transfer completes.
//  - PADDR_o/PWDATA_o/PWRITE_o hold their last captured value outside transfers.
//  - No new transfer starts until req_sync is seen low after ack_o rise, i.e. no back-to-back
//    replay of a held req.
//  - A req_i glitch/drop during SETUP/ACCESS is ignored: the APB transfer always completes,
//    then the FSM waits for req low.
//  - Local PREADY_i never asserted: the FSM stays in ACCESS indefinitely (no timeout).
//  - Reset mid-transfer: outputs drop to 0 asynchronously.
//    If req_i is still high after reset release, a fresh transfer starts.
//    Both ends must be reset together.
// TESTING
//  1. Write A=0x1000 D=0xCAFEBABE, PREADY_i tied 1:
//     one SETUP + one ACCESS cycle with those values on PADDR_o/PWDATA_o/PWRITE_o=1.
//     ack_o rises T0+3 and falls 1 cycle after req_sync=0.
//  2. Read A=0x2004, slave returns 0x12345678 after 3 wait states:
//     PENABLE_o high 4 cycles; async_PRDATA_o=0x12345678 when ack_o rises;
//     value held through the next null request.
//  3. Slave returns PSLVERR_i=1 on a read:
//     async_PSLVERR_o=1 at ack rise; next good transfer clears it to 0.
//  4. async_PSEL_i=0 with req:
//     no PSEL_o pulse; ack completes 4-phase; PSLVERR_o=0; PRDATA_o unchanged.
//  5. req_i held high past ack:
//     exactly one APB transfer; ack_o stays 1 until req drops;
//     then 10 back-to-back handshakes with random dest/src clock ratios (1:3, 3:1, 7:5),
//     each replayed exactly once with correct data.
//  6. rst_n asserted during ACCESS:
//     PSEL_o/PENABLE_o/ack_o go 0 immediately; after release with req_i=1, a new SETUP
//     follows 3 cycles later.

Source files
------------

// File: rtl/apb_slave_asynch.sv
`timescale 1ns/1ps
// apb_slave_asynch: destination-domain end of the APB req/ack CDC bridge.
// Synchronises the 4-phase request, replays it as a local two-phase APB
// transfer and returns the captured response together with the acknowledge.
module apb_slave_asynch #(
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // source-domain handshake and quasi-static request bundle
  input  logic                      asynch_req_i,
  output logic                      asynch_ack_o,
  input  logic [APB_ADDR_WIDTH-1:0] async_PADDR_i,
  input  logic [APB_DATA_WIDTH-1:0] async_PWDATA_i,
  input  logic                      async_PWRITE_i,
  input  logic                      async_PSEL_i,
  output logic [APB_DATA_WIDTH-1:0] async_PRDATA_o,
  output logic                      async_PSLVERR_o,
  // local APB master port
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  output logic                      PWRITE_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SETUP        = 2'd1,
    ACCESS       = 2'd2,
    WAIT_REQ_LOW = 2'd3
  } state_t;

  state_t state;
  logic   req_meta;
  logic   req_sync;

  // Two-flop synchroniser for the request; the bundle is only sampled while req_sync is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= asynch_req_i;
      req_sync <= req_meta;
    end
  end

  // Transfer FSM: replay the request on local APB, capture the response, run the ack phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      asynch_ack_o    <= 1'b0;
      async_PRDATA_o  <= '0;
      async_PSLVERR_o <= 1'b0;
      PADDR_o         <= '0;
      PWDATA_o        <= '0;
      PWRITE_o        <= 1'b0;
      PSEL_o          <= 1'b0;
      PENABLE_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_sync) begin
            if (async_PSEL_i) begin
              PADDR_o  <= async_PADDR_i;
              PWDATA_o <= async_PWDATA_i;
              PWRITE_o <= async_PWRITE_i;
              PSEL_o   <= 1'b1;
              state    <= SETUP;
            end else begin
              // Null request: acknowledge without touching the local bus or read data.
              async_PSLVERR_o <= 1'b0;
              asynch_ack_o    <= 1'b1;
              state           <= WAIT_REQ_LOW;
            end
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Request level is ignored here: a started transfer always completes.
          if (PREADY_i) begin
            async_PRDATA_o  <= PRDATA_i;
            async_PSLVERR_o <= PSLVERR_i;
            PSEL_o          <= 1'b0;
            PENABLE_o       <= 1'b0;
            asynch_ack_o    <= 1'b1;
            state           <= WAIT_REQ_LOW;
          end
        end
        WAIT_REQ_LOW: begin
          // Hold ack until the request is seen low, so a held request is never replayed.
          if (!req_sync) begin
            asynch_ack_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
